fless: RTL and testbench
========================

// Module: fless
//
// PURPOSE
//   IEEE-754 single-precision "less than" comparator for the FPU (flt-style op).
//   Returns y=1 when x1 < x2 as real numbers, else 0.
//   Purely combinational result path. clk/rstn exist only to match the
//   common FPU unit interface.
//
// PARAMETERS
//   (none)
//
// PORTS  (positional instantiation order: x1, x2, y, clk, rstn)
//   clk    input   1   system clock; one clock domain; not used by the result path
//   rstn   input   1   reset, asynchronous, active-low; no state to reset
//   x1     input  32   operand A, IEEE-754 binary32 {sign[31], exp[30:23], man[22:0]}
//   x2     input  32   operand B, same format
//   y      output  1   1 iff x1 < x2 (IEEE ordered less-than)
//
// BEHAVIOUR
//   - Latency 0: y is a combinational function of x1 and x2 only.
//     It settles within the same delta/time step and needs no clock edge.
//   - y is independent of clk and rstn.
//     y is valid with clk idle/X and rstn undriven.
//     No registers are inferred. Reset has no observable effect.
//   - NaN (exp==255, man!=0) on either operand -> y=0 (unordered compares false).
//   - Zeros: +0 and -0 compare equal, so (+0,-0), (-0,+0) and (x,x) all give y=0.
//   - Infinities are ordered normally.
//     -inf < any finite < +inf. (+inf,+inf) -> 0. (-inf,+inf) -> 1.
//   - Denormals are compared exactly, with no flush-to-zero.
//     The smallest denormal 0x00000001 > +0.
//   - Ordering rule for non-NaN, not-both-zero operands:
//       * signs differ: y = s1 (the negative operand is smaller).
//       * both positive: y = (x1[30:0] < x2[30:0]), unsigned magnitude compare.
//       * both negative: y = (x1[30:0] > x2[30:0]).
//   - Equal bit patterns always give y=0. Exception: NaN also gives y=0 by the NaN rule.
//   - Every 32-bit input pair is legal. No X propagation for defined inputs.
//
// TESTING
//   - 0x3F800000(1.0), 0x40000000(2.0) -> y=1. Swapped -> y=0. Equal 1.0,1.0 -> y=0.
//   - 0xBF800000(-1.0) vs 0x3F800000 -> y=1.
//     0xC0000000(-2.0) vs 0xBF800000(-1.0) -> y=1. Swapped -> y=0.
//   - 0x00000000 vs 0x80000000 -> y=0 both orders.
//     0x00000000 vs 0x00000001 -> y=1.
//     0x80000001 vs 0x00000000 -> y=1.
//   - 0xFF800000(-inf) vs 0x7F800000(+inf) -> y=1.
//     0x7F7FFFFF vs 0x7F800000 -> y=1.
//     0x7F800000 vs 0x7F800000 -> y=0.
//   - 0x7FC00000(NaN) vs 0x3F800000 -> y=0 both orders. NaN vs NaN -> y=0.
//   - 500 random vectors, 50% with x2=x1, clk/rstn left undriven.
//     Check y 1 time unit after each input change against a shortreal x1<x2 model.
//     Mismatches are allowed only when an operand is NaN.

Source files
------------

// File: rtl/fless.sv
// Purpose : IEEE-754 binary32 ordered less-than (flt); y=1 iff x1 < x2 as real numbers.
// Latency : 0 cycles; y is a pure combinational function of x1 and x2.
// Backpressure: none; no handshake, the result is valid whenever the operands are.
//
// Ports:
//   x1   [31:0] in  : operand A {sign, exp[7:0], man[22:0]}
//   x2   [31:0] in  : operand B, same format
//   y          out : 1 iff x1 < x2 (NaN on either side gives 0)
//   clk        in  : shared FPU-unit clock, not used by the result path
//   rstn       in  : async active-low reset, nothing to reset here
module fless (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        y,
  input  logic        clk,
  input  logic        rstn
);

  logic        s1, s2;
  logic [30:0] mag1, mag2;
  logic        nan1, nan2;
  logic        both_zero;
  logic        mag_lt, mag_gt;

  // clk/rstn exist only to keep the common FPU port list; fold them into a
  // sink so the unused inputs are visibly intentional.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rstn;

  assign s1   = x1[31];
  assign s2   = x2[31];
  assign mag1 = x1[30:0];
  assign mag2 = x2[30:0];

  // NaN: all-ones exponent with a non-zero mantissa.
  assign nan1 = (&x1[30:23]) && (|x1[22:0]);
  assign nan2 = (&x2[30:23]) && (|x2[22:0]);

  // +0 and -0 are equal regardless of sign.
  assign both_zero = (mag1 == 31'd0) && (mag2 == 31'd0);

  // Sign-magnitude encoding: for same-sign operands the {exp,man} field
  // orders like an unsigned integer, which also covers denormals and inf.
  assign mag_lt = (mag1 < mag2);
  assign mag_gt = (mag1 > mag2);

  always_comb begin
    y = 1'b0;
    if (!(nan1 || nan2) && !both_zero) begin
      if (s1 != s2) begin
        y = s1;
      end else if (!s1) begin
        y = mag_lt;
      end else begin
        y = mag_gt;
      end
    end
  end

endmodule

// File: tb/tb_fless.sv
module tb_fless;

  logic [31:0] x1;
  logic [31:0] x2;
  logic        y;
  logic        clk;
  logic        rstn;
  logic        clk_run;

  int checks;
  int failures;

  fless dut (
    .x1   (x1),
    .x2   (x2),
    .y    (y),
    .clk  (clk),
    .rstn (rstn)
  );

  always #5 if (clk_run) clk = ~clk;

  // Numeric value of a binary32 pattern as a real. Every finite binary32 is
  // exactly representable in double; infinities map to values beyond the
  // finite range so ordering stays correct.
  function automatic real f32_value(input logic [31:0] b);
    real v;
    int  sh;
    logic [7:0] e;
    logic [22:0] m;
    e = b[30:23];
    m = b[22:0];
    if (e == 8'hFF) begin
      v = 1.0e300;
    end else begin
      if (e == 8'd0) begin
        v  = real'(m);
        sh = 1 - 150;
      end else begin
        v  = real'({1'b1, m});
        sh = int'(e) - 150;
      end
      for (int i = 0; i < sh; i++) v = v * 2.0;
      for (int i = 0; i > sh; i--) v = v / 2.0;
    end
    return b[31] ? -v : v;
  endfunction

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return f32_value(a) < f32_value(b);
  endfunction

  task automatic check(input logic [31:0] a, input logic [31:0] b,
                       input logic exp_y, input string tag);
    x1 = a;
    x2 = b;
    #1;
    checks++;
    assert (y === exp_y) else begin
      failures++;
      $error("FAIL %s x1=%08h x2=%08h y=%b expected=%b", tag, a, b, y, exp_y);
    end
  endtask

  function automatic logic [31:0] rand_f32();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) r[30:23] = 8'h00;
    else if (sel == 1) r[30:23] = 8'hFF;
    else if (sel == 2) r[22:0] = 23'd0;
    return r;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks   = 0;
    failures = 0;
    clk_run  = 1'b1;
    clk      = 1'b0;
    rstn     = 1'b0;

    // Reset asserted: output must already reflect the operands.
    check(32'h3F800000, 32'h40000000, 1'b1, "rst_1lt2");
    check(32'h40000000, 32'h3F800000, 1'b0, "rst_2lt1");
    #12;
    rstn = 1'b1;
    #7;

    check(32'h3F800000, 32'h40000000, 1'b1, "1lt2");
    check(32'h40000000, 32'h3F800000, 1'b0, "2lt1");
    check(32'h3F800000, 32'h3F800000, 1'b0, "1lt1");
    check(32'hBF800000, 32'h3F800000, 1'b1, "m1lt1");
    check(32'h3F800000, 32'hBF800000, 1'b0, "1ltm1");
    check(32'hC0000000, 32'hBF800000, 1'b1, "m2ltm1");
    check(32'hBF800000, 32'hC0000000, 1'b0, "m1ltm2");
    check(32'h00000000, 32'h80000000, 1'b0, "p0ltm0");
    check(32'h80000000, 32'h00000000, 1'b0, "m0ltp0");
    check(32'h00000000, 32'h00000001, 1'b1, "p0ltden");
    check(32'h00000001, 32'h00000000, 1'b0, "denltp0");
    check(32'h80000001, 32'h00000000, 1'b1, "mdenltp0");
    check(32'h80000001, 32'h80000000, 1'b1, "mdenltm0");
    check(32'hFF800000, 32'h7F800000, 1'b1, "minfltpinf");
    check(32'h7F800000, 32'hFF800000, 1'b0, "pinfltminf");
    check(32'h7F7FFFFF, 32'h7F800000, 1'b1, "maxltinf");
    check(32'h7F800000, 32'h7F800000, 1'b0, "infltinf");
    check(32'hFF800000, 32'hFF7FFFFF, 1'b1, "minfltmmax");
    check(32'h7FC00000, 32'h3F800000, 1'b0, "nanlt1");
    check(32'h3F800000, 32'h7FC00000, 1'b0, "1ltnan");
    check(32'h7FC00000, 32'h7FC00000, 1'b0, "nanltnan");
    check(32'hFF800001, 32'h7F800000, 1'b0, "mnanltinf");
    check(32'h007FFFFF, 32'h00800000, 1'b1, "denltnorm");

    // Reset toggling mid-run must not disturb the result.
    rstn = 1'b0;
    check(32'hC0000000, 32'hBF800000, 1'b1, "rst_mid");
    rstn = 1'b1;

    // Random phase with clock and reset left undriven.
    clk_run = 1'b0;
    clk     = 1'bx;
    rstn    = 1'bz;
    for (int n = 0; n < 500; n++) begin
      a = rand_f32();
      if ($urandom_range(0, 1) == 0) begin
        b = a;
      end else begin
        b = rand_f32();
        if ($urandom_range(0, 3) == 0) b[31] = ~a[31];
      end
      check(a, b, ref_lt(a, b), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
